// File: rtl/gearbox_pack_if.sv
// Stream bundle for gearbox_pack: narrow symbol input side and wide word output side.
// slave is the packer's view, master is the view of whoever feeds and drains it.
interface gearbox_pack_if #(
    parameter int IN_WIDTH  = 7,
    parameter int OUT_WIDTH = 32
);
    logic                 valid_in;
    logic                 ready_in;
    logic [IN_WIDTH-1:0]  data_in;
    logic                 first_in;
    logic                 last_in;
    logic                 valid_out;
    logic                 ready_out;
    logic [OUT_WIDTH-1:0] data_out;
    logic                 first_packet;
    logic                 last_packet;

    modport master (
        output valid_in, data_in, first_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, first_packet, last_packet
    );

    modport slave (
        input  valid_in, data_in, first_in, last_in, ready_out,
        output ready_in, valid_out, data_out, first_packet, last_packet
    );
endinterface

// File: rtl/gearbox_pack.sv
// Narrow-to-wide packer: IN_WIDTH-bit symbols, LSB-first, into zero-padded OUT_WIDTH-bit framed words.
// Define GEARBOX_PACK_OVERFLOW_EN to add a sticky overflow output for symbols offered while not ready.
module gearbox_pack #(
    parameter int IN_WIDTH  = 7,
    parameter int OUT_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    gearbox_pack_if.slave bus
`ifdef GEARBOX_PACK_OVERFLOW_EN
    ,
    output logic          overflow
`endif
);
    localparam int ACC_W = OUT_WIDTH + IN_WIDTH - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_WIDTH);

    logic [ACC_W-1:0] acc_q, acc_d, sym_ext;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             flush_q, flush_d;
    logic             sof_q, sof_d;
    logic             valid_out, ready_in, last_word, push, pop;

    // ready_in depends on ready_out so a full word can drain and refill in one cycle.
    always_comb begin
        valid_out = (cnt_q >= OUT_CNT) || (flush_q && (cnt_q != '0));
        last_word = valid_out && flush_q && (cnt_q <= OUT_CNT);
        pop       = valid_out && bus.ready_out;
        ready_in  = !flush_q && ((cnt_q < OUT_CNT) || pop);
        push      = bus.valid_in && ready_in;
    end

    assign bus.valid_out    = valid_out;
    assign bus.ready_in     = ready_in;
    assign bus.data_out     = acc_q[OUT_WIDTH-1:0];
    assign bus.first_packet = valid_out && sof_q;
    assign bus.last_packet  = last_word;

    // Bits above cnt are kept zero, so inserting a symbol is a plain OR at the fill point.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        sof_d    = sof_q;
        cnt_base = cnt_q;
        sym_ext  = ACC_W'(bus.data_in);
        if (pop) begin
            sof_d = 1'b0;
            if (last_word) begin
                acc_d    = '0;
                cnt_base = '0;
                flush_d  = 1'b0;
            end else begin
                acc_d    = acc_q >> OUT_WIDTH;
                cnt_base = (cnt_q >= OUT_CNT) ? (cnt_q - OUT_CNT) : '0;
            end
            cnt_d = cnt_base;
        end
        if (push) begin
            acc_d = acc_d | (sym_ext << cnt_base);
            cnt_d = cnt_base + IN_CNT;
            if (bus.first_in) begin
                sof_d = 1'b1;
            end
            if (bus.last_in) begin
                flush_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            sof_q   <= sof_d;
        end
    end

`ifdef GEARBOX_PACK_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (bus.valid_in && !ready_in) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif
endmodule

// File: tb/tb_gearbox_pack.sv
// Bench for gearbox_pack: a pending-bit queue model checked every cycle, plus directed literal cases.
module tb_gearbox_pack;
    logic clk = 1'b0;
    logic rst_n;
`ifdef GEARBOX_PACK_OVERFLOW_EN
    logic overflow;
`endif

    gearbox_pack_if #(.IN_WIDTH(7), .OUT_WIDTH(32)) gb ();

    gearbox_pack #(.IN_WIDTH(7), .OUT_WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (gb)
`ifdef GEARBOX_PACK_OVERFLOW_EN
        ,
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls   = 0;
    bit chk_en   = 0;
    bit rand_ro  = 0;

    // Model: stream bits accepted but not yet emitted, plus frame status.
    bit bq[$];
    bit m_flush = 0;
    bit m_sof   = 0;
    bit m_ovf   = 0;

    logic [31:0] cap_d[$];
    bit          cap_f[$];
    bit          cap_l[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int          n;
        logic [31:0] ew;
        logic        ev, ef, el, eri, epop, epush;
        bit          dummy;
        if (chk_en) begin
            n   = bq.size();
            ev  = (n >= 32) || (m_flush && n != 0);
            ef  = ev && m_sof;
            el  = ev && m_flush && (n <= 32);
            eri = !m_flush && ((n < 32) || (ev && gb.ready_out));
            for (int k = 0; k < 32; k++) ew[k] = (k < n) ? bq[k] : 1'b0;
            check("valid_out", gb.valid_out, ev);
            check("ready_in", gb.ready_in, eri);
            check("data_out", gb.data_out, ew);
            check("first_packet", gb.first_packet, ef);
            check("last_packet", gb.last_packet, el);
`ifdef GEARBOX_PACK_OVERFLOW_EN
            check("overflow", overflow, m_ovf);
`endif
            epop  = ev && gb.ready_out;
            epush = gb.valid_in && eri;
            if (!rst_n) begin
                bq.delete();
                m_flush = 0;
                m_sof   = 0;
                m_ovf   = 0;
            end else begin
                if (gb.valid_in && !eri) m_ovf = 1;
                if (epop) begin
                    cap_d.push_back(gb.data_out);
                    cap_f.push_back(gb.first_packet);
                    cap_l.push_back(gb.last_packet);
                    for (int k = 0; k < 32 && bq.size() > 0; k++) dummy = bq.pop_front();
                    if (el) begin
                        bq.delete();
                        m_flush = 0;
                    end
                    m_sof = 0;
                end
                if (epush) begin
                    for (int k = 0; k < 7; k++) bq.push_back(gb.data_in[k]);
                    if (gb.first_in) m_sof = 1;
                    if (gb.last_in) m_flush = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ro) gb.ready_out = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle_in();
        gb.valid_in = 0;
        gb.first_in = 0;
        gb.last_in  = 0;
    endtask

    task automatic send(input logic [6:0] d, input logic f, input logic l);
        int   waited;
        logic took;
        waited = 0;
        took   = 0;
        gb.valid_in = 1;
        gb.data_in  = d;
        gb.first_in = f;
        gb.last_in  = l;
        while (!took && waited < 300) begin
            @(negedge clk);
            took = gb.ready_in;
            if (!took) begin
                stalls++;
                waited++;
            end
            tick();
        end
        check("send_accepted", took, 1);
        idle_in();
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            tick();
            done = (bq.size() == 0) && !m_flush;
        end
        check("drain_done", done, 1);
    endtask

    task automatic clear_cap();
        cap_d.delete();
        cap_f.delete();
        cap_l.delete();
    endtask

    task automatic do_reset();
        rst_n = 0;
        gb.valid_in = 1;
        repeat (3) tick();
        rst_n = 1;
        idle_in();
    endtask

    task automatic padded_frame();
        for (int i = 0; i < 5; i++) send(7'h7F, i == 0, i == 4);
        @(negedge clk);
        check("pad_ready_in_flush", gb.ready_in, 0);
    endtask

    task automatic check_padded(input string tag);
        check({tag, "_nwords"}, cap_d.size(), 2);
        if (cap_d.size() == 2) begin
            check({tag, "_w0"}, cap_d[0], 32'hFFFF_FFFF);
            check({tag, "_w0_first"}, cap_f[0], 1);
            check({tag, "_w0_last"}, cap_l[0], 0);
            check({tag, "_w1"}, cap_d[1], 32'h0000_0007);
            check({tag, "_w1_first"}, cap_f[1], 0);
            check({tag, "_w1_last"}, cap_l[1], 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        gb.data_in   = '0;
        gb.ready_out = 1;
        idle_in();
        rst_n = 0;
        gb.valid_in = 1;
        @(posedge clk);
        #1;
        chk_en = 1;
        tick();
        tick();
        rst_n = 1;
        idle_in();
        @(negedge clk);
        check("reset_ready_in", gb.ready_in, 1);
        check("reset_valid_out", gb.valid_out, 0);
        check("reset_nwords", cap_d.size(), 0);
        tick();

        // Aligned frame: 224 bits fill exactly 7 words, with no stall at full rate.
        clear_cap();
        stalls = 0;
        for (int i = 0; i < 32; i++) send(7'(i + 1), i == 0, i == 31);
        check("aligned_stalls", stalls, 0);
        wait_idle();
        check("aligned_nwords", cap_d.size(), 7);
        if (cap_d.size() == 7) begin
            check("aligned_w0", cap_d[0], 32'h5080_C101);
            for (int i = 0; i < 7; i++) begin
                check("aligned_first", cap_f[i], i == 0);
                check("aligned_last", cap_l[i], i == 6);
            end
        end

        clear_cap();
        padded_frame();
        wait_idle();
        check_padded("padded");

        // Backpressure with 35 bits held, then a pop and push in the same cycle.
        clear_cap();
        gb.ready_out = 0;
        for (int i = 0; i < 5; i++) send(7'h7F, i == 0, 0);
        gb.valid_in = 1;
        gb.data_in  = 7'h55;
        gb.last_in  = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data_stable", gb.data_out, 32'hFFFF_FFFF);
            check("bp_ready_in", gb.ready_in, 0);
            check("bp_valid_out", gb.valid_out, 1);
            tick();
        end
        gb.ready_out = 1;
        @(negedge clk);
        check("bp_release_ready_in", gb.ready_in, 1);
        tick();
        idle_in();
        wait_idle();
        check("bp_nwords", cap_d.size(), 2);
        if (cap_d.size() == 2) begin
            check("bp_w0", cap_d[0], 32'hFFFF_FFFF);
            check("bp_w1", cap_d[1], 32'h0000_02AF);
            check("bp_w1_last", cap_l[1], 1);
        end

        // Mid-frame reset discards partial data; the next frame is clean.
        for (int i = 0; i < 3; i++) send(7'(i + 9), i == 0, 0);
        do_reset();
        clear_cap();
`ifdef GEARBOX_PACK_OVERFLOW_EN
        @(negedge clk);
        check("ovf_after_reset", overflow, 0);
`endif
        padded_frame();
`ifdef GEARBOX_PACK_OVERFLOW_EN
        gb.valid_in = 1;
        gb.data_in  = 7'h11;
        tick();
        idle_in();
        @(negedge clk);
        check("ovf_set", overflow, 1);
`endif
        wait_idle();
        check_padded("after_reset");

        // Random frames, gaps and sink stalls.
        rand_ro = 1;
        for (int fr = 0; fr < 40; fr++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) tick();
                send(7'($urandom_range(0, 127)), i == 0, i == len - 1);
            end
        end
        wait_idle();
        rand_ro = 0;
        gb.ready_out = 1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
